// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receiver state encoding and clog2 helper
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: fractional accumulator emitting a one-cycle tick at RATE Hz from CLK_FREQ
module uart_tick_gen import uart_pkg::*; #(
    parameter int CLK_FREQ = 100000000,
    parameter int RATE     = 153600
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = clog2(CLK_FREQ + RATE) + 1;

    logic [W-1:0] acc;
    logic [W-1:0] sum;

    assign sum = acc + W'(RATE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= W'(CLK_FREQ)) begin
            acc  <= sum - W'(CLK_FREQ);
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with majority voting, error flags and output FIFO
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 overrun,
    input  logic                 err_clear,
    output logic                 break_det
);
    import uart_pkg::*;

    localparam int CW = clog2(OVERSAMPLE);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam int W  = DATA_BITS + 2;
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);

    logic                 tick;
    logic [1:0]           sync;
    logic [2:0]           smp;
    logic                 maj;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           nbit;
    logic [DATA_BITS-1:0] shift;
    logic                 perr;
    logic                 ferr;
    logic                 plow;
    logic                 push;
    logic [W-1:0]         word;
    logic [W-1:0]         mem [FIFO_DEPTH];
    logic [AW:0]          wp;
    logic [AW:0]          rp;
    logic                 full;
    logic                 pop;
    logic                 wr;
    logic [W-1:0]         head;

    uart_tick_gen #(.CLK_FREQ(CLK_FREQ), .RATE(BAUD * OVERSAMPLE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            smp  <= 3'b111;
        end else begin
            sync <= {sync[0], rxd};
            if (tick) smp <= {smp[1:0], sync[1]};
        end
    end

    assign maj = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            nbit      <= '0;
            shift     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            plow      <= 1'b0;
            push      <= 1'b0;
            word      <= '0;
            break_det <= 1'b0;
        end else begin
            push      <= 1'b0;
            break_det <= 1'b0;
            case (state)
                S_IDLE: if (!sync[1]) begin
                    cnt   <= '0;
                    nbit  <= '0;
                    perr  <= 1'b0;
                    ferr  <= 1'b0;
                    plow  <= 1'b0;
                    state <= S_START;
                end
                S_START: if (tick) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= maj ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: if (tick) begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        shift <= {maj, shift[DATA_BITS-1:1]};
                        nbit  <= nbit + 1'b1;
                        if (nbit == 4'(DATA_BITS - 1)) begin
                            nbit  <= '0;
                            state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: if (tick) begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        perr  <= (PARITY == PAR_ODD) ? ~(^shift ^ maj) : (^shift ^ maj);
                        plow  <= !maj;
                        state <= S_STOP;
                    end
                end
                S_STOP: if (tick) begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        nbit <= nbit + 1'b1;
                        ferr <= ferr | !maj;
                        // leave half a bit early so a back-to-back start edge is not missed
                        if (nbit == 4'(STOP_BITS - 1)) begin
                            push      <= 1'b1;
                            word      <= {perr, ferr | !maj, shift};
                            break_det <= (shift == '0) && (PARITY == PAR_NONE || plow) && (ferr | !maj);
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop  = rx_valid && rx_ready;
    assign wr   = push && (!full || pop);
    assign head = mem[rp[AW-1:0]];

    assign rx_valid      = wp != rp;
    assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_frame_err  = rx_valid & head[DATA_BITS];
    assign rx_parity_err = rx_valid & head[DATA_BITS+1];

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push && full && !pop) overrun <= 1'b1;
            else if (err_clear) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed plus randomized checks of 8N1, 7E1 and 8N2 receivers against a frame-level model
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rxd = 3'b111;
    logic [2:0] ready = 3'b000;
    logic [2:0] clr = 3'b000;
    logic [2:0] valid, ferr, perr, ovr, brk;
    logic [7:0] d0, d2;
    logic [6:0] d1;
    int         checks = 0;
    int         failures = 0;
    int         brk_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    always @(negedge clk) for (int i = 0; i < 3; i++) if (brk[i]) brk_cnt[i]++;

    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .OVERSAMPLE(16), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .rx_data(d0), .rx_valid(valid[0]), .rx_ready(ready[0]),
        .rx_frame_err(ferr[0]), .rx_parity_err(perr[0]), .overrun(ovr[0]), .err_clear(clr[0]),
        .break_det(brk[0]));

    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1),
                  .OVERSAMPLE(16), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .rx_data(d1), .rx_valid(valid[1]), .rx_ready(ready[1]),
        .rx_frame_err(ferr[1]), .rx_parity_err(perr[1]), .overrun(ovr[1]), .err_clear(clr[1]),
        .break_det(brk[1]));

    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2),
                  .OVERSAMPLE(16), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .rxd(rxd[2]), .rx_data(d2), .rx_valid(valid[2]), .rx_ready(ready[2]),
        .rx_frame_err(ferr[2]), .rx_parity_err(perr[2]), .overrun(ovr[2]), .err_clear(clr[2]),
        .break_det(brk[2]));

    function automatic int nb(input int ch);
        return ch == 1 ? 7 : 8;
    endfunction

    function automatic int pm(input int ch);
        return ch == 1 ? 2 : 0;
    endfunction

    function automatic int ns(input int ch);
        return ch == 2 ? 2 : 1;
    endfunction

    function automatic logic [8:0] dat(input int ch);
        return ch == 0 ? {1'b0, d0} : ch == 1 ? {2'b0, d1} : {1'b0, d2};
    endfunction

    // {parity_err, frame_err, break} expected for one frame
    function automatic logic [2:0] model(input int ch, input logic [8:0] d, input logic pb, input logic [1:0] st);
        int   ones = $countones(d) + int'(pb);
        logic pe, fe, bk;
        pe = pm(ch) == 2 ? (ones % 2 == 1) : pm(ch) == 1 ? (ones % 2 == 0) : 1'b0;
        fe = ns(ch) == 2 ? !(st[0] && st[1]) : !st[0];
        bk = (d == 9'd0) && (pm(ch) == 0 || !pb) && fe;
        return {pe, fe, bk};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ch, input logic [8:0] d, input logic pb, input logic [1:0] st);
        logic [15:0] bits = '1;
        int          n = 1;
        bits[0] = 1'b0;
        for (int i = 0; i < nb(ch); i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pm(ch) != 0) begin
            bits[n] = pb;
            n++;
        end
        for (int i = 0; i < ns(ch); i++) begin
            bits[n] = st[i];
            n++;
        end
        for (int i = 0; i < n; i++) begin
            rxd[ch] = bits[i];
            repeat (16) @(negedge clk);
        end
        rxd[ch] = 1'b1;
    endtask

    task automatic expect_word(input int ch, input logic [8:0] d, input logic pe, input logic fe, input string tag);
        int n = 0;
        while (!valid[ch] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(valid[ch]), 32'd1);
        check({tag, " word"}, {21'd0, perr[ch], ferr[ch], dat(ch)}, {21'd0, pe, fe, d});
        ready[ch] = 1'b1;
        @(negedge clk);
        ready[ch] = 1'b0;
    endtask

    task automatic rand_check(input int ch, input logic [8:0] d, input logic pb, input logic [1:0] st);
        logic [2:0] m = model(ch, d, pb, st);
        int         b = brk_cnt[ch];
        send(ch, d, pb, st);
        expect_word(ch, d, m[2], m[1], "rand");
        check("rand break", 32'(brk_cnt[ch] - b), 32'(m[0]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " flags"}, {17'd0, valid, ferr, perr, ovr, brk}, 32'd0);
        check({tag, " data"}, {9'd0, d0, d1, d2}, 32'd0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [8:0] d;
        logic [8:0] q [$];
        int         b;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send(0, 9'h0A5, 1'b0, 2'b11);
        expect_word(0, 9'h0A5, 1'b0, 1'b0, "basic");
        check("basic popped", 32'(valid[0]), 32'd0);

        send(1, 9'h003, 1'b1, 2'b11);
        expect_word(1, 9'h003, 1'b1, 1'b0, "parity bad");
        send(1, 9'h003, 1'b0, 2'b11);
        expect_word(1, 9'h003, 1'b0, 1'b0, "parity good");

        // a low final stop bit looks like a new start edge, so clear the half-received frame
        send(2, 9'h05A, 1'b0, 2'b01);
        expect_word(2, 9'h05A, 1'b0, 1'b1, "stop2 low");
        reset_pulse();

        b = brk_cnt[0];
        rxd[0] = 1'b0;
        repeat (192) @(negedge clk);
        rxd[0] = 1'b1;
        check("break pulses", 32'(brk_cnt[0] - b), 32'd1);
        expect_word(0, 9'h000, 1'b0, 1'b1, "break");
        reset_pulse();

        rxd[0] = 1'b0;
        repeat (3) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch no push", 32'(valid[0]), 32'd0);
        send(0, 9'h05A, 1'b0, 2'b11);
        expect_word(0, 9'h05A, 1'b0, 1'b0, "after glitch");

        for (int i = 1; i <= 5; i++) send(0, 9'(i * 17), 1'b0, 2'b11);
        check("overrun set", 32'(ovr[0]), 32'd1);
        for (int i = 1; i <= 4; i++) expect_word(0, 9'(i * 17), 1'b0, 1'b0, "drain");
        check("drained", 32'(valid[0]), 32'd0);
        check("overrun sticky", 32'(ovr[0]), 32'd1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("overrun cleared", 32'(ovr[0]), 32'd0);

        for (int i = 0; i < 4; i++) begin
            d = 9'($urandom_range(0, 255));
            q.push_back(d);
            send(0, d, 1'b0, 2'b11);
        end
        check("full no overrun", 32'(ovr[0]), 32'd0);
        while (q.size() > 0) expect_word(0, q.pop_front(), 1'b0, 1'b0, "fifo order");

        send(0, 9'h077, 1'b0, 2'b11);
        check("pre-reset valid", 32'(valid[0]), 32'd1);
        d = 9'h09C;
        rxd[0] = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd[0] = d[i];
            repeat (16) @(negedge clk);
        end
        rxd[0] = d[3];
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid-frame reset");
        rxd[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(0, 9'h09C, 1'b0, 2'b11);
        expect_word(0, 9'h09C, 1'b0, 1'b0, "after reset");
        check("after reset empty", 32'(valid[0]), 32'd0);

        for (int k = 0; k < 6; k++)
            rand_check(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b11);
        for (int k = 0; k < 6; k++)
            rand_check(2, k == 0 ? 9'd0 : 9'($urandom_range(0, 255)), 1'b0,
                       {1'b1, k == 0 ? 1'b0 : 1'($urandom_range(0, 1))});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that succeeds the fixed 8N1 receiver. It adds configurable data width, parity, stop-bit count and oversampling, plus 3-sample majority voting and per-word error flags. Received words go into a small output FIFO with a valid/ready handshake, and break and overrun conditions are reported. It sits between the board RxD pin and any byte-consuming logic (command parser, DMA bridge).

## Interface
Parameters:
- `CLK_FREQ`, 100000000, clock frequency in Hz.
- `BAUD`, 9600, line bit rate.
- `DATA_BITS`, 8, data bits per frame, legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `OVERSAMPLE`, 16, ticks per bit; power of 2, at least 8.
- `FIFO_DEPTH`, 4, output FIFO entries; power of 2, at least 2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  serial line, asynchronous, idles high.
- `rx_data`  out  DATA_BITS  word at the FIFO head.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head word.
- `rx_frame_err`  out  1  head word had a low stop bit; qualified by `rx_valid`.
- `rx_parity_err`  out  1  head word failed the parity check; qualified by `rx_valid`.
- `overrun`  out  1  sticky; a word arrived while the FIFO was full.
- `err_clear`  in  1  clears `overrun`.
- `break_det`  out  1  one-cycle pulse when a break is detected.

## Operation
- **Tick generator:** fractional accumulator producing `tick` at `BAUD*OVERSAMPLE`. Rounding error is held to within ±2% over one frame.
- **Input path:** `rxd` passes through a 2-flop synchroniser (reset value 1), then a 3-deep shift register loaded on `tick`.
- **IDLE:** a synchronised low starts the frame. The tick counter is cleared and the FSM moves to START.
- **START:** after `OVERSAMPLE/2` ticks, take the majority of the last 3 samples.
  - Majority high: false start, return to IDLE with no push.
  - Majority low: go to DATA.
- **DATA:** sample every `OVERSAMPLE` ticks using the majority vote. Bits are shifted in LSB-first. After `DATA_BITS` samples go to PARITY if `PARITY != 0`, otherwise to STOP.
- **PARITY:** one sample. `parity_err` is set when the XOR of the data bits and the parity bit is 0 in odd mode, or 1 in even mode.
- **STOP:** `STOP_BITS` samples. `frame_err` is set if any stop sample is low.
  - After the last stop sample, push `{parity_err, frame_err, data}` and return to IDLE immediately (half a bit early), so back-to-back frames are accepted.
- **Break:** data all zero, parity sample low (when enabled) and `frame_err` set. `break_det` pulses in the push cycle; the word is still pushed with `frame_err=1`.
- **FIFO:** pointer-based, one extra pointer bit for full/empty.
  - Pop on `rx_valid && rx_ready`.
  - Push while full with no simultaneous pop: the new word is dropped and `overrun` is set. Existing contents are unchanged.
  - Push and pop in the same cycle while full: both take effect and `overrun` is not set.
- **Overrun clear:** `err_clear` clears `overrun`. If `err_clear` and a new overrun occur in the same cycle, `overrun` stays set.

## Timing
- **Reset values:**
  - `rx_valid`, `rx_frame_err`, `rx_parity_err`, `overrun`, `break_det` are all 0.
  - `rx_data` is 0.
  - FSM is in IDLE, FIFO is empty, accumulator is 0.
- **Reset mid-frame:** the partial frame is discarded and the FIFO is emptied.
- **Start latency:** 2 cycles from an `rxd` edge to the synchronised bit.
- **Push latency:** the push happens on the clock after the final stop-sample tick. `rx_valid` rises the following cycle.
- **Read path:** `rx_data` and the error flags are combinational reads of the head entry and change only on a pop or when the FIFO goes from empty to non-empty.
- **Pop rate:** one pop per cycle is sustainable.
- **Frame length:** 1 + `DATA_BITS` + (`PARITY != 0`) + `STOP_BITS` bits. Only one frame is in flight at a time.

## Structure
- **Shared package `uart_pkg`:**
  - Parity-mode constants `PAR_NONE=0`, `PAR_ODD=1`, `PAR_EVEN=2`.
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - `clog2` function.
- **Sub-module `uart_tick_gen`:** the fractional tick accumulator (parameters `CLK_FREQ`, `RATE`), reusable by a future parametrised transmitter.
- **In the top module:** the FIFO is inline, `DATA_BITS+2` bits wide.

## Test plan
Unless stated otherwise, all scenarios use `CLK_FREQ=1600000`, `BAUD=100000`, `OVERSAMPLE=16`, which gives one tick per clock.
- **8N1 basic:** send 0xA5 -> one `rx_valid` with `rx_data=0xA5` and both error flags 0. Pop with `rx_ready=1` -> `rx_valid` goes to 0.
- **Parity error:** `PARITY=2`, `DATA_BITS=7`; send 0x03 with parity bit 1 -> `rx_data=0x03`, `rx_parity_err=1`. Same data with parity bit 0 -> `rx_parity_err=0`.
- **Frame error and break:** 8N2 with the second stop bit low -> `rx_frame_err=1`. Hold `rxd` low for 12 bit times -> `break_det` pulses once and a word of 0x00 with `rx_frame_err=1` is pushed.
- **Glitch:** `rxd` low for 3 ticks, then high -> no push and the FSM returns to IDLE.
- **Overrun:** `FIFO_DEPTH=4`, `rx_ready=0`; send 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> `overrun=1`, and draining yields 0x11..0x44 only. `err_clear` -> `overrun=0`.
- **Reset mid-frame:** assert `rst` during data bit 3 -> all outputs are 0. After release, send 0x9C -> received 0x9C cleanly.
